// File: rtl/reg_pkg.sv
// Shared definitions for the universal register: operation-select encodings.
package reg_pkg;

    localparam int          MODE_W    = 3;
    localparam logic [2:0]  MODE_HOLD = 3'b000;
    localparam logic [2:0]  MODE_LOAD = 3'b001;
    localparam logic [2:0]  MODE_SHL  = 3'b010;
    localparam logic [2:0]  MODE_SHR  = 3'b011;
    localparam logic [2:0]  MODE_ROTL = 3'b100;
    localparam logic [2:0]  MODE_ROTR = 3'b101;
    localparam logic [2:0]  MODE_INC  = 3'b110;
    localparam logic [2:0]  MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_reg_next.sv
// Combinational next-value and next-carry datapath for univ_reg.
module univ_reg_next #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_carry,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);
    import reg_pkg::*;

    // Select the single operation for this cycle; HOLD and unknown keep state.
    always_comb begin
        o_data  = i_data;
        o_carry = i_carry;
        case (i_mode)
            MODE_HOLD: begin
                o_data  = i_data;
                o_carry = i_carry;
            end
            MODE_LOAD: begin
                o_data  = i_data_in;
            end
            MODE_SHL: begin
                o_data  = {i_data[WIDTH-2:0], i_ser_in};
                o_carry = i_data[WIDTH-1];
            end
            MODE_SHR: begin
                o_data  = {i_ser_in, i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            MODE_ROTL: begin
                o_data  = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
                o_carry = i_data[WIDTH-1];
            end
            MODE_ROTR: begin
                o_data  = {i_data[0], i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            MODE_INC: begin
                // The extra top bit of the widened sum is exactly the wrap flag.
                {o_carry, o_data} = {1'b0, i_data} + {{WIDTH{1'b0}}, 1'b1};
            end
            MODE_DEC: begin
                o_data  = i_data - {{(WIDTH-1){1'b0}}, 1'b1};
                o_carry = (i_data == {WIDTH{1'b0}});
            end
            default: begin
                o_data  = i_data;
                o_carry = i_carry;
            end
        endcase
    end

endmodule

// File: rtl/univ_reg.sv
// Universal register: state flops with clear/enable priority and a zero flag.
module univ_reg #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             zero
);
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic [WIDTH-1:0] w_nxt_data;
    logic             w_nxt_carry;

    univ_reg_next #(.WIDTH(WIDTH)) u_next (
        .i_data    (r_data),
        .i_carry   (r_carry),
        .i_mode    (mode),
        .i_data_in (data_in),
        .i_ser_in  (ser_in),
        .o_data    (w_nxt_data),
        .o_carry   (w_nxt_carry)
    );

    // State update: reset, then clear, then enable-gated operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= RESET_VALUE;
            r_carry <= 1'b0;
        end else if (clr) begin
            r_data  <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
        end else if (en) begin
            r_data  <= w_nxt_data;
            r_carry <= w_nxt_carry;
        end else begin
            r_data  <= r_data;
            r_carry <= r_carry;
        end
    end

    assign data_out = r_data;
    assign carry    = r_carry;
    assign zero     = (r_data == {WIDTH{1'b0}});

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg (WIDTH=8, RESET_VALUE=A5) with directed vectors.
module tb_univ_reg;
    import reg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [2:0] mode;
    logic [7:0] data_in;
    logic       ser_in;
    logic [7:0] data_out;
    logic       carry;
    logic       zero;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       c;
        logic       z;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   n_compared = 0;
    int   n_failed   = 0;
    bit   done       = 1'b0;

    univ_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .mode     (mode),
        .data_in  (data_in),
        .ser_in   (ser_in),
        .data_out (data_out),
        .carry    (carry),
        .zero     (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string name, input logic [7:0] ed, input logic ec, input logic ez);
        n_compared++;
        if (data_out !== ed) begin
            n_failed++;
            $display("FAIL %s data_out: got %h, expected %h", name, data_out, ed);
        end
        n_compared++;
        if (carry !== ec) begin
            n_failed++;
            $display("FAIL %s carry: got %b, expected %b", name, carry, ec);
        end
        n_compared++;
        if (zero !== ez) begin
            n_failed++;
            $display("FAIL %s zero: got %b, expected %b", name, zero, ez);
        end
    endtask

    // Monitor: after each rising edge, check every expectation due by this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                compare(e.name, e.d, e.c, e.z);
            end
        end
    end

    task automatic push_exp(input string name, input logic [7:0] ed, input logic ec);
        exp_t e;
        e.cyc  = cyc + 1;
        e.d    = ed;
        e.c    = ec;
        e.z    = (ed == 8'h00);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step(input logic i_en, input logic i_clr, input logic [2:0] i_mode,
                        input logic [7:0] i_din, input logic i_ser,
                        input logic [7:0] ed, input logic ec, input string name);
        @(negedge clk);
        en      = i_en;
        clr     = i_clr;
        mode    = i_mode;
        data_in = i_din;
        ser_in  = i_ser;
        push_exp(name, ed, ec);
    endtask

    initial begin
        rst_n   = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        mode    = MODE_HOLD;
        data_in = 8'h00;
        ser_in  = 1'b0;

        // Asynchronous reset between edges
        #12 rst_n = 1'b0;
        #1  compare("reset_async", 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 1'b0, MODE_LOAD, 8'h3C, 1'b0, 8'h3C, 1'b0, "load_3c");
        step(1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h3C, 1'b0, "hold_en0_1");
        step(1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h3C, 1'b0, "hold_en0_2");
        step(1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h3C, 1'b0, "hold_en0_3");

        step(1'b1, 1'b0, MODE_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, "load_81");
        step(1'b1, 1'b0, MODE_SHL,  8'h00, 1'b0, 8'h02, 1'b1, "shl_81");
        step(1'b1, 1'b0, MODE_SHR,  8'h00, 1'b1, 8'h81, 1'b0, "shr_02_ser1");

        step(1'b1, 1'b0, MODE_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, "load_80");
        step(1'b1, 1'b0, MODE_ROTL, 8'h00, 1'b0, 8'h01, 1'b1, "rotl_80");
        step(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b0, 8'hFF, 1'b1, "load_ff_keeps_carry");
        step(1'b1, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h00, 1'b1, "inc_wrap");
        step(1'b1, 1'b0, MODE_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, "dec_wrap");

        step(1'b1, 1'b0, MODE_LOAD, 8'h01, 1'b0, 8'h01, 1'b1, "load_01");
        step(1'b1, 1'b0, MODE_ROTR, 8'h00, 1'b1, 8'h80, 1'b1, "rotr_01");
        step(1'b1, 1'b0, MODE_DEC,  8'h00, 1'b0, 8'h7F, 1'b0, "dec_80");
        step(1'b1, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h80, 1'b0, "inc_7f");
        step(1'b1, 1'b0, MODE_SHR,  8'h00, 1'b0, 8'h40, 1'b0, "shr_80_unsigned");
        step(1'b1, 1'b0, MODE_HOLD, 8'hEE, 1'b1, 8'h40, 1'b0, "hold_mode");
        step(1'b1, 1'b0, MODE_SHL,  8'h00, 1'b1, 8'h81, 1'b0, "shl_40_ser1");

        step(1'b1, 1'b1, MODE_LOAD, 8'h55, 1'b0, 8'h00, 1'b0, "clr_over_load");
        step(1'b1, 1'b0, MODE_LOAD, 8'h12, 1'b0, 8'h12, 1'b0, "load_12");
        step(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0, 8'h00, 1'b0, "clr_en0");

        step(1'b1, 1'b0, MODE_LOAD, 8'h05, 1'b0, 8'h05, 1'b0, "load_05");
        step(1'b1, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h06, 1'b0, "inc_05");
        step(1'b1, 1'b0, MODE_INC,  8'h00, 1'b0, 8'h07, 1'b0, "inc_06");

        // Reset pulse in the middle of the INC run, released before the next edge
        @(negedge clk);
        en   = 1'b1;
        clr  = 1'b0;
        mode = MODE_INC;
        #1 rst_n = 1'b0;
        #1 compare("reset_midrun", 8'hA5, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        push_exp("inc_after_reset", 8'hA6, 1'b0);
        step(1'b1, 1'b0, MODE_INC,  8'h00, 1'b0, 8'hA7, 1'b0, "inc_a6");

        @(negedge clk);
        en = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_compared++;
            n_failed++;
            $display("FAIL %s: expectation never checked, expected data_out %h", e.name, e.d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/univ_reg.md
UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 Parameter WIDTH, default 16, register width in bits; SHALL be legal for any value >= 2.
REQ-002 Parameter RESET_VALUE, default 0, value data_out SHALL take on reset; WIDTH bits.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  operation enable; 0 SHALL hold all state.
REQ-006 clr  input  1  synchronous clear; SHALL have priority over en and mode.
REQ-007 mode  input  3  operation select; encodings are in REQ-011.
REQ-008 data_in  input  WIDTH  parallel load data.
REQ-009 ser_in  input  1  serial fill bit for the shift modes.
REQ-010 data_out  output  WIDTH  registered value; carry  output  1  registered flag; zero  output  1  combinational flag, 1 when data_out == 0.

Function
REQ-011 Mode encodings SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110 INC, 111 DEC.
REQ-012 Priority per rising edge SHALL be, highest first:
- rst_n low;
- clr = 1: data_out <= 0, carry <= 0;
- en = 0: hold;
- otherwise: the selected mode.
REQ-013 HOLD SHALL keep data_out and carry unchanged.
REQ-014 LOAD SHALL set data_out <= data_in and leave carry unchanged.
REQ-015 SHL SHALL set data_out <= {data_out[WIDTH-2:0], ser_in} and carry <= old data_out[WIDTH-1].
REQ-016 SHR SHALL set data_out <= {ser_in, data_out[WIDTH-1:1]} and carry <= old data_out[0].
REQ-017 ROTL and ROTR SHALL rotate by one bit without using ser_in; carry <= the bit that wrapped around.
REQ-018 INC SHALL set data_out <= data_out + 1, modulo 2^WIDTH; carry SHALL be 1 only when wrapping from all-ones to 0, otherwise 0.
REQ-019 DEC SHALL set data_out <= data_out - 1, modulo 2^WIDTH; carry SHALL be 1 only when wrapping from 0 to all-ones, otherwise 0.
REQ-020 Latency: the result of each operation SHALL be visible on data_out and carry one cycle after the edge; zero SHALL follow data_out with no added delay.
REQ-021 Shifts and arithmetic SHALL be unsigned; no sign extension.
REQ-022 Each cycle SHALL perform exactly one operation; inputs SHALL be sampled only at the rising edge.

Reset
REQ-023 While rst_n is low, and immediately on its assertion regardless of clk, data_out SHALL be RESET_VALUE and carry SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL abort that operation; the first operation after deassertion SHALL take effect on the first rising edge with rst_n high.

Structure
REQ-025 The mode encodings SHALL be defined as named constants in the shared package reg_pkg.
REQ-026 Next-state and next-carry computation SHALL live in one combinational sub-module, univ_reg_next.
REQ-027 univ_reg SHALL contain only the state flops, clr/en priority and the zero flag.

Verification (WIDTH=8, RESET_VALUE=8'hA5)
REQ-028 Reset: rst_n low between clock edges -> data_out = A5 and carry = 0 at once; zero = 0.
REQ-029 Load and hold:
- LOAD 3C, en=1 -> data_out = 3C;
- en=0, mode INC, 3 cycles -> data_out stays 3C.
REQ-030 Shift:
- LOAD 81, then SHL with ser_in=0 -> data_out = 02, carry = 1;
- then SHR with ser_in=1 -> data_out = 81, carry = 0.
REQ-031 Rotate and wrap:
- LOAD 80, ROTL -> data_out = 01, carry = 1;
- LOAD FF, INC -> data_out = 00, carry = 1, zero = 1;
- DEC -> data_out = FF, carry = 1.
REQ-032 Priority: clr=1 with en=1, mode LOAD, data_in 55 -> data_out = 00, carry = 0.
REQ-033 Reset mid-run: pulse rst_n low during an INC sequence at data_out 07 -> data_out = A5, carry = 0; INC resumes from A5 on the next edge.
